// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C RTC target: FSM states, DS1307
// register indices and BCD rollover limits.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } tgt_state_t;

    typedef enum logic [2:0] {
        REG_SEC   = 3'd0,
        REG_MIN   = 3'd1,
        REG_HOUR  = 3'd2,
        REG_DAY   = 3'd3,
        REG_DATE  = 3'd4,
        REG_MONTH = 3'd5,
        REG_YEAR  = 3'd6,
        REG_CTRL  = 3'd7
    } rtc_reg_t;

    localparam logic [7:0] BCD_MAX_MIN_SEC = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR    = 8'h23;

    // Two-digit BCD increment that wraps to 00 once the limit is reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] limit);
        logic [7:0] result;
        if (value >= limit) begin
            result = 8'h00;
        end else if (value[3:0] >= 4'h9) begin
            result = {value[7:4] + 4'h1, 4'h0};
        end else begin
            result = value + 8'h01;
        end
        return result;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes sclk/sda into the clk domain and produces one-clk pulses for
// sclk rise/fall, START and STOP, plus the sda level aligned with those pulses.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic sda_in,
    output logic sda_smp,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;
    logic       scl_rise_q, scl_rise_d;
    logic       scl_fall_q, scl_fall_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;

    // Bits [1:0] are the synchronizer, bit [2] is the previous sample for edge detection.
    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], sclk};
        sda_pipe_d = {sda_pipe_q[1:0], sda_in};
        scl_rise_d = scl_pipe_q[1] & ~scl_pipe_q[2];
        scl_fall_d = ~scl_pipe_q[1] & scl_pipe_q[2];
        start_d    = scl_pipe_q[1] & scl_pipe_q[2] & ~sda_pipe_q[1] & sda_pipe_q[2];
        stop_d     = scl_pipe_q[1] & scl_pipe_q[2] & sda_pipe_q[1] & ~sda_pipe_q[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_pipe_q <= 3'b111;
            sda_pipe_q <= 3'b111;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_smp   = sda_pipe_q[2];
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_rtc_target.sv
// I2C target exposing a DS1307-style eight-register RTC map with auto-incrementing pointer.
// Define RTC_TARGET_TICK_EN to add the 1 Hz tick input and the BCD sec/min/hour counter.
module i2c_rtc_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h68,
    parameter logic [63:0] REG_INIT = 64'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    inout  wire        sda,
`ifdef RTC_TARGET_TICK_EN
    input  logic       tick,
`endif
    output logic       busy,
    output logic       wr_stb,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data
);

    logic sda_smp, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .sda_in    (sda),
        .sda_smp   (sda_smp),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    tgt_state_t state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] ptr_q, ptr_d;
    logic       first_q, first_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_stb_q, wr_stb_d;
    logic [2:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] regs_q [8];
    logic [7:0] regs_d [8];
    logic [7:0] byte_in;
`ifdef RTC_TARGET_TICK_EN
    logic       sec_wrap, min_wrap;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        regs_d    = regs_q;
        byte_in   = {shift_q[6:0], sda_smp};

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = byte_in[0];
                                first_d = 1'b1;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                // First fall drives the ACK low, second fall ends the ACK bit.
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_d  = ST_RD_LOAD;
                                sda_oe_d = ~regs_q[ptr_q][7];
                            end else begin
                                state_d = ST_WR_BYTE;
                            end
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = ST_WR_ACK;
                            if (first_q) begin
                                ptr_d   = byte_in[2:0];
                                first_d = 1'b0;
                            end else begin
                                regs_d[ptr_q] = byte_in;
                                wr_stb_d      = 1'b1;
                                wr_addr_d     = ptr_q;
                                wr_data_d     = byte_in;
                                ptr_d         = ptr_q + 3'd1;
                            end
                        end
                    end
                end
                // The MSB was already put on the bus at the preceding fall.
                ST_RD_LOAD: begin
                    shift_d   = regs_q[ptr_q];
                    ptr_d     = ptr_q + 3'd1;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_RD_BYTE;
                end
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_smp) begin
                            state_d = ST_IGNORE;
                        end else begin
                            bit_cnt_d = 4'd9;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        state_d  = ST_RD_LOAD;
                        sda_oe_d = ~regs_q[ptr_q][7];
                    end
                end
                default: begin
                end
            endcase
        end

`ifdef RTC_TARGET_TICK_EN
        // A bus write committed this cycle takes priority over the tick for that register.
        sec_wrap = regs_q[REG_SEC] >= BCD_MAX_MIN_SEC;
        min_wrap = regs_q[REG_MIN] >= BCD_MAX_MIN_SEC;
        if (tick && !regs_q[REG_SEC][7]) begin
            if (!(wr_stb_d && wr_addr_d == REG_SEC))
                regs_d[REG_SEC] = bcd_inc(regs_q[REG_SEC], BCD_MAX_MIN_SEC);
            if (sec_wrap && !(wr_stb_d && wr_addr_d == REG_MIN))
                regs_d[REG_MIN] = bcd_inc(regs_q[REG_MIN], BCD_MAX_MIN_SEC);
            if (sec_wrap && min_wrap && !(wr_stb_d && wr_addr_d == REG_HOUR))
                regs_d[REG_HOUR] = bcd_inc(regs_q[REG_HOUR], BCD_MAX_HOUR);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= 3'd0;
            first_q   <= 1'b0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 3'd0;
            wr_data_q <= 8'h00;
            for (int i = 0; i < 8; i++) regs_q[i] <= REG_INIT[8*i +: 8];
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            first_q   <= first_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            regs_q    <= regs_d;
        end
    end

    // Gating with rst lets a reset release the bus in the same cycle it is applied.
    assign sda     = (sda_oe_q && !rst) ? 1'b0 : 1'bz;
    assign busy    = busy_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
